booth_radix4_mult: RTL and testbench

//  Iterative radix-4 Booth multiplier; parametrised successor to the radix-2 BoothMultiplier.
//  - Retires 2 multiplier bits per cycle.
//  - Runtime signed/unsigned mode.
//  - valid/ready handshakes on both the operand and result sides.
//  - Single clock domain; sits between the operand source and the result consumer in the datapath.

---
 rtl/booth_radix4_mult.sv | 182 ++++++++++++++++++
 tb/tb_booth_radix4_mult.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: iterative radix-4 Booth multiplier with runtime signed/unsigned mode.
// Retires two multiplier bits per cycle and produces the product after ITER = (N+2)/2
// recode cycles. Both sides use valid/ready handshakes.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (0 = reset)
//   in_valid     operands M, Q, signed_mode valid
//   in_ready     block can accept operands (IDLE only)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   M            multiplicand, N bits
//   Q            multiplier, N bits
//   out_valid    P holds a completed product
//   out_ready    consumer takes P
//   P            product M*Q, 2N bits
//   busy         FSM is not IDLE
//
// Optional build macro: BOOTH_ZERO_SKIP_EN
//   When defined, a zero multiplicand or multiplier skips the recode loop and the
//   product (0) is presented one edge after acceptance.

module booth_radix4_mult #(
    parameter int unsigned N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [N-1:0]     M,
    input  logic [N-1:0]     Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   P,
    output logic             busy
);

    // Internal operand width (room for -2M), sum width, iteration count, counter width
    localparam int unsigned W     = N + 2;
    localparam int unsigned AW    = W + 1;
    localparam int unsigned ITER  = (N + 2) / 2;
    localparam int unsigned CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       m_q, m_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       qr_q, qr_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]     p_q, p_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    // Combinational datapath helpers
    logic [W-1:0]       ext_m_c, ext_q_c;
    logic [AW-1:0]      mx_c, dig_c, sum_c;
    logic [W-1:0]       a_next_c, qr_next_c;
    logic [2:0]         booth_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            a_q         <= '0;
            qr_q        <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            a_q         <= a_d;
            qr_q        <= qr_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Operand extension, Booth recode and one add/shift step
    always_comb begin
        ext_m_c = signed_mode ? {{2{M[N-1]}}, M} : {2'b00, M};
        ext_q_c = signed_mode ? {{2{Q[N-1]}}, Q} : {2'b00, Q};
        mx_c    = {m_q[W-1], m_q};
        booth_c = {qr_q[1:0], qm1_q};
        dig_c   = '0;
        case (booth_c)
            3'b001, 3'b010: dig_c = mx_c;
            3'b011:         dig_c = {m_q, 1'b0};
            3'b100:         dig_c = AW'(0) - {m_q, 1'b0};
            3'b101, 3'b110: dig_c = AW'(0) - mx_c;
            default:        dig_c = '0;
        endcase
        // One guard bit keeps the sum exact; the arithmetic shift by 2 brings it back to W bits
        sum_c     = {a_q[W-1], a_q} + dig_c;
        a_next_c  = {sum_c[AW-1], sum_c[AW-1:2]};
        qr_next_c = {sum_c[1:0], qr_q[W-1:2]};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        a_d         = a_q;
        qr_d        = qr_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    m_d        = ext_m_c;
                    qr_d       = ext_q_c;
                    a_d        = '0;
                    qm1_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                a_d   = a_next_c;
                qr_d  = qr_next_c;
                qm1_d = qr_q[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    p_d         = {a_next_c[N-3:0], qr_next_c};
                end
`ifdef BOOTH_ZERO_SKIP_EN
                // qr_q still holds the untouched multiplier on the first CALC cycle
                if ((cnt_q == '0) && ((m_q == '0) || (qr_q == '0))) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    p_d         = '0;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult (N=32): directed corner cases plus
// randomized operands against a plain-arithmetic reference product.

module tb_booth_radix4_mult;

    localparam int unsigned N    = 32;
    localparam int unsigned ITER = (N + 2) / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           signed_mode = 1'b0;
    logic [N-1:0]   M = '0;
    logic [N-1:0]   Q = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] P;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    booth_radix4_mult #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .M           (M),
        .Q           (Q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .P           (P),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: extend both operands to 64 bits per mode, the low 64 bits of the product are exact
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sm);
        logic [63:0] ea, eb;
        ea = sm ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sm ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return ITER;
    endfunction

    // Issue one product, check latency/result, hold out_ready low for 'hold' cycles, then retire it
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input int hold);
        int          lat;
        int          waitc;
        logic        rdy_low_ok;
        logic        stable_ok;
        logic [63:0] expv;
        expv  = ref_mul(a, b, sm);
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        M           = a;
        Q           = b;
        signed_mode = sm;
        @(posedge clk); #1;
        // Operands and mode are free to change once accepted
        in_valid    = 1'b0;
        M           = $urandom;
        Q           = $urandom;
        signed_mode = ~sm;
        lat         = 0;
        rdy_low_ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_low_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_latency(a, b)));
        check({tag, " product"}, P, expv);
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || P !== expv || in_ready || !busy) stable_ok = 1'b0;
        end
        if (in_ready) rdy_low_ok = 1'b0;
        check({tag, " in_ready low while busy"}, 64'(rdy_low_ok), 64'd1);
        if (hold > 0) check({tag, " stall stable"}, 64'(stable_ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " retire idle"}, {61'd0, out_valid, busy, in_ready}, 64'd1);
        check({tag, " P held"}, P, expv);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        repeat (3) @(posedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset P", P, 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        do_op("t1 5*7", 32'd5, 32'd7, 1'b0, 0);
        do_op("t2 -3*10", 32'hFFFF_FFFD, 32'd10, 1'b1, 1);
        do_op("t3 unsigned ff*ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op("t3 signed -1*-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        do_op("t4 signed min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        do_op("t4 unsigned 2^31 sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        do_op("t5 stall", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10);
        do_op("zero M", 32'd0, 32'd7, 1'b0, 0);
        do_op("zero Q signed", 32'hDEAD_BEEF, 32'd0, 1'b1, 0);

        // Reset mid-CALC abandons the operation
        in_valid = 1'b1; M = 32'd99; Q = 32'd77; signed_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("t6 rst abort", {61'd0, out_valid, busy, 1'b0}, 64'd0);
        check("t6 rst P", P, 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        do_op("t6 12*5", 32'd12, 32'd5, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 5) == 0) ra = {1'b1, 31'd0};
            do_op($sformatf("rand%0d", k), ra, rb, rs, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
